jtopll_wrbuf: RTL and testbench

Write-pacing buffer in front of the YM2413 core. Accepts single-cycle CPU port writes (address port / data port) at full bus speed, stores them in a small FIFO, and replays them to the core's `din`/`addr`/`cs_n`/`wr_n` pins. Consecutive writes are separated by the chip's minimum intervals: 12 ticks after an address write and 84 ticks after a data write. The CPU never needs wait states.

---
 rtl/jtopll_wrbuf_pkg.sv | 26 ++
 rtl/jtopll_wrbuf_fifo.sv | 67 ++++++
 rtl/jtopll_wrbuf.sv | 111 +++++++++++
 tb/tb_jtopll_wrbuf.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtopll_wrbuf_pkg.sv
// Shared types and defaults for the YM2413 write-pacing buffer.
package jtopll_wrbuf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2
  } state_t;

  // One queued bus write: which port, and the byte written to it.
  typedef struct packed {
    logic       addr;
    logic [7:0] data;
  } entry_t;

  localparam int DEF_ADDR_WAIT = 12;
  localparam int DEF_DATA_WAIT = 84;

  // Bits needed to hold the larger of the two reload values (WAIT-1).
  function automatic int gap_width(input int addr_wait, input int data_wait);
    int m;
    m = (addr_wait > data_wait) ? addr_wait : data_wait;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/jtopll_wrbuf_fifo.sv
// Synchronous FIFO of pending OPLL writes with registered level/full/empty.
module jtopll_wrbuf_fifo
  import jtopll_wrbuf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  entry_t              wr_data,
  output entry_t              rd_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_ONE    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] LVL_NEARLY = (DEPTH_LOG2+1)'(DEPTH - 1);

  entry_t                mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Writes while full are dropped here; the top flags them as overflow.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Entry storage.
  // NOTE: the storage array has no reset; the pointers and flags define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy flags; reset flushes the queue.
  // NOTE: every sequential assignment is non-blocking so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10: begin
          level <= level + 1'b1;
          full  <= (level == LVL_NEARLY);
          empty <= 1'b0;
        end
        2'b01: begin
          level <= level - 1'b1;
          full  <= 1'b0;
          empty <= (level == LVL_ONE);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/jtopll_wrbuf.sv
// Write-pacing buffer for the YM2413 core: queues CPU port writes and replays
// them with the chip's minimum address/data intervals.
// Optional build macro: JTOPLL_WRBUF_PEAK_EN adds a peak-level monitor
// (output peak, input peak_clr).
module jtopll_wrbuf
  import jtopll_wrbuf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int ADDR_WAIT  = DEF_ADDR_WAIT,
  parameter int DATA_WAIT  = DEF_DATA_WAIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cen,
  input  logic                cpu_we,
  input  logic                cpu_addr,
  input  logic [7:0]          cpu_din,
  output logic                full,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  output logic [7:0]          opll_din,
  output logic                opll_addr,
  output logic                opll_cs_n,
  output logic                opll_wr_n
`ifdef JTOPLL_WRBUF_PEAK_EN
  ,
  input  logic                peak_clr,
  output logic [DEPTH_LOG2:0] peak
`endif
);

  localparam int GAP_W = gap_width(ADDR_WAIT, DATA_WAIT);
  localparam logic [GAP_W-1:0] ADDR_RELOAD = GAP_W'(ADDR_WAIT - 1);
  localparam logic [GAP_W-1:0] DATA_RELOAD = GAP_W'(DATA_WAIT - 1);

  state_t           state;
  logic [GAP_W-1:0] gap;
  entry_t           head;
  entry_t           wr_entry;
  logic             empty;
  logic             pop;

  assign wr_entry = '{addr: cpu_addr, data: cpu_din};

  // A strobe starts (and the FIFO pops) on a tick from IDLE, or from GAP once
  // the interval has fully elapsed.
  assign pop = cen && !empty &&
               ((state == IDLE) || ((state == GAP) && (gap == '0)));

  jtopll_wrbuf_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cpu_we),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // Pacing FSM, gap counter and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gap       <= '0;
      opll_din  <= '0;
      opll_addr <= 1'b0;
      opll_cs_n <= 1'b1;
      opll_wr_n <= 1'b1;
    end else if (cen) begin
      if (gap != '0) gap <= gap - 1'b1;
      if (pop) begin
        state     <= STROBE;
        opll_din  <= head.data;
        opll_addr <= head.addr;
        opll_cs_n <= 1'b0;
        opll_wr_n <= 1'b0;
        gap       <= head.addr ? DATA_RELOAD : ADDR_RELOAD;
      end else begin
        case (state)
          STROBE: begin
            state     <= GAP;
            opll_cs_n <= 1'b1;
            opll_wr_n <= 1'b1;
          end
          GAP:     if (gap == '0) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Sticky flag for writes dropped while the FIFO was full.
  always_ff @(posedge clk) begin
    if (rst)                 overflow <= 1'b0;
    else if (cpu_we && full) overflow <= 1'b1;
  end

`ifdef JTOPLL_WRBUF_PEAK_EN
  // High-water mark of the FIFO level; peak_clr restarts it from the current level.
  always_ff @(posedge clk) begin
    if (rst)               peak <= '0;
    else if (peak_clr)     peak <= level;
    else if (level > peak) peak <= level;
  end
`endif

endmodule

// File: tb/tb_jtopll_wrbuf.sv
// Self-checking bench for jtopll_wrbuf: table-driven fill/overflow vectors,
// a strobe scoreboard and hand-written multi-cycle sequences.
module tb_jtopll_wrbuf;
  import jtopll_wrbuf_pkg::*;

  localparam int DL2 = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cen = 1'b0;
  logic           cpu_we = 1'b0;
  logic           cpu_addr = 1'b0;
  logic [7:0]     cpu_din = 8'h00;
  logic           full;
  logic [DL2:0]   level;
  logic           overflow;
  logic [7:0]     opll_din;
  logic           opll_addr;
  logic           opll_cs_n;
  logic           opll_wr_n;
`ifdef JTOPLL_WRBUF_PEAK_EN
  logic           peak_clr = 1'b0;
  logic [DL2:0]   peak;
`endif

  jtopll_wrbuf #(
    .DEPTH_LOG2 (DL2),
    .ADDR_WAIT  (12),
    .DATA_WAIT  (84)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .full      (full),
    .level     (level),
    .overflow  (overflow),
    .opll_din  (opll_din),
    .opll_addr (opll_addr),
    .opll_cs_n (opll_cs_n),
    .opll_wr_n (opll_wr_n)
`ifdef JTOPLL_WRBUF_PEAK_EN
    ,
    .peak_clr  (peak_clr),
    .peak      (peak)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] exp_q[$];
  int         starts[$];
  int         widths[$];
  int         last_start = 0;
  logic       prev_cs = 1'b1;

  // cen pattern: 0 = every clk, 1 = every 4th clk, 2 = stalled, 3 = driven by the test
  int cen_mode = 0;
  int phase = 0;
  always @(negedge clk) begin
    if (cen_mode != 3) begin
      case (cen_mode)
        0:       cen = 1'b1;
        1:       cen = (phase == 0);
        default: cen = 1'b0;
      endcase
    end
    phase = (phase + 1) % 4;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Strobe monitor / scoreboard consumer
  always @(posedge clk) begin
    #1;
    if (!opll_cs_n && prev_cs) begin
      starts.push_back(cyc);
      last_start = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL strobe_unexpected: got {addr,din}=0x%0h, required no strobe", {opll_addr, opll_din});
      end else begin
        check("strobe_data", {23'd0, opll_addr, opll_din}, {23'd0, exp_q.pop_front()});
      end
      check("strobe_wr_n", {31'd0, opll_wr_n}, 32'd0);
    end
    if (opll_cs_n && !prev_cs) widths.push_back(cyc - last_start);
    prev_cs = opll_cs_n;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cpu_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    starts.delete();
    widths.delete();
  endtask

  task automatic write_one(input logic a, input logic [7:0] d);
    @(negedge clk);
    cpu_we = 1'b1;
    cpu_addr = a;
    cpu_din = d;
    exp_q.push_back({a, d});
  endtask

  task automatic bus_idle();
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int k = 0;
    while (starts.size() < n && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    check(name, starts.size(), n);
  endtask

  typedef struct {
    logic       a;
    logic [7:0] d;
    logic       acc;
    int         lvl;
    logic       f;
    logic       ovf;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 8'hA0, 1'b1, 1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'hA1, 1'b1, 2, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'hA2, 1'b1, 3, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'hA3, 1'b1, 4, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'hA4, 1'b1, 5, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'hA5, 1'b1, 6, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'hA6, 1'b1, 7, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 8'hA7, 1'b1, 8, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 8'hA8, 1'b0, 8, 1'b1, 1'b1};
    tbl[9] = '{1'b1, 8'hA9, 1'b0, 8, 1'b1, 1'b1};

    // ---- reset values ----
    cen_mode = 0;
    do_reset();
    check("rst_level", {28'd0, level}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_cs_n", {31'd0, opll_cs_n}, 32'd1);
    check("rst_wr_n", {31'd0, opll_wr_n}, 32'd1);
    check("rst_din", {24'd0, opll_din}, 32'd0);
    check("rst_addr", {31'd0, opll_addr}, 32'd0);

    // ---- single address/data pair, cen every clk ----
    write_one(1'b0, 8'h10);
    write_one(1'b1, 8'h55);
    bus_idle();
    wait_starts(2, 100, "t1_strobes");
    repeat (3) @(posedge clk);
    #2;
    if (starts.size() == 2) check("t1_spacing", starts[1] - starts[0], 12);
    check("t1_widths_seen", widths.size(), 2);
    if (widths.size() == 2) begin
      check("t1_width0", widths[0], 1);
      check("t1_width1", widths[1], 1);
    end
    check("t1_hold_din", {24'd0, opll_din}, 32'h55);
    check("t1_hold_addr", {31'd0, opll_addr}, 32'd1);

    // ---- data-to-data spacing, cen every 4th clk ----
    cen_mode = 1;
    do_reset();
    write_one(1'b1, 8'h01);
    write_one(1'b1, 8'h02);
    write_one(1'b1, 8'h03);
    bus_idle();
    wait_starts(3, 1200, "t2_strobes");
    repeat (6) @(posedge clk);
    #2;
    if (starts.size() == 3) begin
      check("t2_spacing_a", starts[1] - starts[0], 336);
      check("t2_spacing_b", starts[2] - starts[1], 336);
    end
    if (widths.size() >= 1) check("t2_width", widths[0], 4);
    check("t2_sb_empty", exp_q.size(), 0);

    // ---- overflow: table-driven fill with the pacer stalled ----
    cen_mode = 2;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cpu_we = 1'b1;
      cpu_addr = tbl[i].a;
      cpu_din = tbl[i].d;
      if (tbl[i].acc) exp_q.push_back({tbl[i].a, tbl[i].d});
      @(posedge clk);
      #1;
      check($sformatf("t3_level_%0d", i), {28'd0, level}, tbl[i].lvl);
      check($sformatf("t3_full_%0d", i), {31'd0, full}, {31'd0, tbl[i].f});
      check($sformatf("t3_ovf_%0d", i), {31'd0, overflow}, {31'd0, tbl[i].ovf});
    end
    bus_idle();
    cen_mode = 0;
    wait_starts(8, 2000, "t3_replayed");
    repeat (200) @(posedge clk);
    #2;
    check("t3_no_extra", starts.size(), 8);
    check("t3_sb_empty", exp_q.size(), 0);
    check("t3_level_drained", {28'd0, level}, 32'd0);
    check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);

    // ---- simultaneous push and pop at level 3 ----
    cen_mode = 2;
    do_reset();
    write_one(1'b0, 8'h31);
    write_one(1'b0, 8'h32);
    write_one(1'b0, 8'h33);
    @(negedge clk);
    cen_mode = 3;
    cen = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 1'b0;
    cpu_din = 8'h34;
    exp_q.push_back({1'b0, 8'h34});
    @(posedge clk);
    #1;
    check("t4_level_same", {28'd0, level}, 32'd3);
    check("t4_strobe_now", {31'd0, opll_cs_n}, 32'd0);
    @(negedge clk);
    cpu_we = 1'b0;
    cen = 1'b0;
    cen_mode = 0;
    wait_starts(4, 200, "t4_strobes");
    check("t4_sb_empty", exp_q.size(), 0);

    // ---- reset mid-strobe ----
    cen_mode = 2;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cpu_we = 1'b1;
      cpu_addr = 1'b0;
      cpu_din = 8'h60 + 8'(i);
      if (i < 8) exp_q.push_back({1'b0, 8'h60 + 8'(i)});
    end
    bus_idle();
    check("t5_ovf_before", {31'd0, overflow}, 32'd1);
    cen_mode = 1;
    begin
      int k = 0;
      while (opll_cs_n && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    check("t5_strobe_seen", {31'd0, opll_cs_n}, 32'd0);
    rst = 1'b1;
    cpu_we = 1'b1;
    cpu_din = 8'hEE;
    @(posedge clk);
    #1;
    check("t5_cs_n_released", {31'd0, opll_cs_n}, 32'd1);
    check("t5_wr_n_released", {31'd0, opll_wr_n}, 32'd1);
    check("t5_level_flushed", {28'd0, level}, 32'd0);
    check("t5_ovf_cleared", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cpu_we = 1'b0;
    exp_q.delete();
    starts.delete();
    repeat (400) @(posedge clk);
    #2;
    check("t5_no_strobes", starts.size(), 0);
    check("t5_level_still0", {28'd0, level}, 32'd0);

`ifdef JTOPLL_WRBUF_PEAK_EN
    // ---- peak monitor ----
    cen_mode = 2;
    do_reset();
    for (int i = 0; i < 5; i++) write_one(1'b0, 8'h80 + 8'(i));
    bus_idle();
    cen_mode = 0;
    wait_starts(5, 400, "t6_strobes");
    repeat (4) @(posedge clk);
    #2;
    check("t6_peak", {28'd0, peak}, 32'd5);
    @(negedge clk);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    check("t6_peak_clr", {28'd0, peak}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
